// File: rtl/pe_loop_sequencer_pkg.sv
// Shared opcodes, mode encodings and sequencer states for the PE local store command bus.
// Pure definitions: no latency, no flow control.
package pe_loop_sequencer_pkg;

  localparam int LSC_DEPTH = 2;
  localparam int LSC_A     = 7;
  localparam int CFG_CODES = 4;

  typedef enum logic [2:0] {
    OP_INIT      = 3'b000,
    OP_HOLD      = 3'b001,
    OP_INCR      = 3'b010,
    OP_JUMP      = 3'b011,
    OP_SET_K_ROW = 3'b100,
    OP_SET_K_COL = 3'b101,
    OP_SET_N_ROW = 3'b110,
    OP_SET_N_COL = 3'b111
  } op_e;

  localparam logic [1:0] MODE_CONFIG  = 2'b00;
  localparam logic [1:0] MODE_LOAD    = 2'b01;
  localparam logic [1:0] MODE_COMPUTE = 2'b10;
  localparam logic [1:0] MODE_RSVD    = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CFG,
    ST_LOAD,
    ST_CMP_INIT,
    ST_CMP_RUN,
    ST_CMP_JUMP,
    ST_FIN
  } state_e;

  function automatic logic [5:0] ctl_word(input logic [2:0] kcmd, input logic [2:0] ncmd);
    return {kcmd, ncmd};
  endfunction

endpackage

// File: rtl/pe_loop_sequencer_nested_loop_counter.sv
// Outer/inner loop counter pair; inner wraps at inner_max_i and carries into outer.
// Next values are exported so the caller can register outputs decoded from them.
module nested_loop_counter #(
  parameter int W = 7
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] inner_max_i,
  input  logic [W-1:0] outer_max_i,
  output logic [W-1:0] inner_d_o,
  output logic [W-1:0] outer_d_o,
  output logic         inner_last_o,
  output logic         outer_last_o
);

  logic [W-1:0] inner_q, inner_d;
  logic [W-1:0] outer_q, outer_d;

  assign inner_last_o = (inner_q == inner_max_i);
  assign outer_last_o = (outer_q == outer_max_i);
  assign inner_d_o    = inner_d;
  assign outer_d_o    = outer_d;

  always_comb begin
    inner_d = inner_q;
    outer_d = outer_q;
    if (clr_i) begin
      inner_d = '0;
      outer_d = '0;
    end else if (en_i) begin
      if (inner_last_o) begin
        inner_d = '0;
        outer_d = outer_q + W'(1);
      end else begin
        inner_d = inner_q + W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      inner_q <= '0;
      outer_q <= '0;
    end else begin
      inner_q <= inner_d;
      outer_q <= outer_d;
    end
  end

endmodule

// File: rtl/pe_loop_sequencer.sv
// Sequencer issuing CONFIG / LOAD / COMPUTE command streams to the PE local stores; first command
// is registered on the start edge. stall freezes the walk and drives {HOLD,HOLD} in its place.
module pe_loop_sequencer
  import pe_loop_sequencer_pkg::*;
#(
  parameter  int depth = LSC_DEPTH,
  parameter  int A     = LSC_A,
  localparam int D     = 1 << depth,
  localparam int NPE   = D * D
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [A-1:0]     kRows,
  input  logic [A-1:0]     kCols,
  input  logic             stall,
  output logic [5:0]       controlSignal,
  output logic [NPE-1:0]   initPESelect,
  output logic [depth-1:0] initSettings,
  output logic             kernelWrite,
  output logic             macEn,
  output logic             busy,
  output logic             done,
  output logic             cfgValid
);

  state_e           state_q, state_d;
  logic             cmp_pend_q, cmp_pend_d;
  logic             cfg_valid_q, cfg_valid_d;
  logic [A-1:0]     krows_q, krows_d;
  logic [A-1:0]     kcols_q, kcols_d;
  logic             frozen, cnt_clr, cnt_en;
  logic [A-1:0]     inner_max, outer_max, inner_d, outer_d;
  logic             inner_last, outer_last;

  logic [5:0]       ctl_q, ctl_d;
  logic [NPE-1:0]   sel_q, sel_d;
  logic [depth-1:0] set_q, set_d;
  logic             kw_q, kw_d, mac_q, mac_d, busy_q, busy_d, done_q, done_d;

  // CFG walks (pe, code); LOAD uses inner as word index with 0 = INIT; COMPUTE walks (row, col).
  always_comb begin
    inner_max = A'(CFG_CODES - 1);
    outer_max = A'(NPE - 1);
    case (state_q)
      ST_LOAD: inner_max = kcols_q;
      ST_CMP_INIT, ST_CMP_RUN, ST_CMP_JUMP: begin
        inner_max = kcols_q - A'(1);
        outer_max = krows_q - A'(1);
      end
      default: ;
    endcase
  end

  nested_loop_counter #(.W(A)) u_cnt (
    .clk_i        (CLK),
    .rst_i        (RST),
    .clr_i        (cnt_clr),
    .en_i         (cnt_en),
    .inner_max_i  (inner_max),
    .outer_max_i  (outer_max),
    .inner_d_o    (inner_d),
    .outer_d_o    (outer_d),
    .inner_last_o (inner_last),
    .outer_last_o (outer_last)
  );

  always_comb begin
    state_d     = state_q;
    cmp_pend_d  = cmp_pend_q;
    cfg_valid_d = cfg_valid_q;
    krows_d     = krows_q;
    kcols_d     = kcols_q;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;
    frozen      = stall && (state_q != ST_IDLE) && (state_q != ST_FIN);
    if (!frozen) begin
      case (state_q)
        ST_IDLE, ST_FIN: begin
          state_d = ST_IDLE;
          cnt_clr = 1'b1;
          if (start && (mode != MODE_RSVD)) begin
            krows_d    = kRows;
            kcols_d    = kCols;
            cmp_pend_d = 1'b0;
            case (mode)
              MODE_CONFIG: state_d = ST_CFG;
              MODE_LOAD:   state_d = ST_LOAD;
              default: begin
                if (cfg_valid_q) begin
                  state_d = ST_CMP_INIT;
                end else begin
                  state_d    = ST_CFG;
                  cmp_pend_d = 1'b1;
                end
              end
            endcase
          end
        end
        ST_CFG: begin
          if (inner_last && outer_last) begin
            cfg_valid_d = 1'b1;
            cmp_pend_d  = 1'b0;
            state_d     = cmp_pend_q ? ST_CMP_INIT : ST_FIN;
          end else begin
            cnt_en = 1'b1;
          end
        end
        ST_LOAD: begin
          if (inner_last) state_d = ST_FIN;
          else            cnt_en  = 1'b1;
        end
        ST_CMP_INIT: begin
          cnt_clr = 1'b1;
          state_d = ((krows_q == '0) || (kcols_q == '0)) ? ST_FIN : ST_CMP_RUN;
        end
        ST_CMP_RUN: begin
          if (inner_last) state_d = ST_CMP_JUMP;
          else            cnt_en  = 1'b1;
        end
        ST_CMP_JUMP: begin
          // inner is still at its last value here, so stepping carries into the next row.
          if (outer_last) begin
            state_d = ST_FIN;
          end else begin
            cnt_en  = 1'b1;
            state_d = ST_CMP_RUN;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    ctl_d  = ctl_word(OP_HOLD, OP_HOLD);
    sel_d  = '0;
    set_d  = '0;
    kw_d   = 1'b0;
    mac_d  = 1'b0;
    busy_d = 1'b0;
    done_d = 1'b0;
    if (frozen) begin
      busy_d = 1'b1;
    end else begin
      case (state_d)
        ST_CFG: begin
          ctl_d  = ctl_word({1'b1, inner_d[1:0]}, {1'b1, inner_d[1:0]});
          sel_d  = NPE'(1) << outer_d;
          set_d  = inner_d[0] ? outer_d[depth-1:0] : outer_d[2*depth-1:depth];
          busy_d = 1'b1;
        end
        ST_LOAD: begin
          busy_d = 1'b1;
          if (inner_d == '0) begin
            ctl_d = ctl_word(OP_INIT, OP_HOLD);
          end else begin
            ctl_d = ctl_word(OP_INCR, OP_HOLD);
            kw_d  = 1'b1;
          end
        end
        ST_CMP_INIT: begin
          ctl_d  = ctl_word(OP_INIT, OP_INIT);
          busy_d = 1'b1;
        end
        ST_CMP_RUN: begin
          ctl_d  = ctl_word(OP_INCR, OP_INCR);
          mac_d  = 1'b1;
          busy_d = 1'b1;
        end
        ST_CMP_JUMP: begin
          ctl_d  = ctl_word(OP_JUMP, OP_JUMP);
          busy_d = 1'b1;
        end
        ST_FIN:  done_d = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      cmp_pend_q  <= 1'b0;
      cfg_valid_q <= 1'b0;
      krows_q     <= '0;
      kcols_q     <= '0;
      ctl_q       <= ctl_word(OP_HOLD, OP_HOLD);
      sel_q       <= '0;
      set_q       <= '0;
      kw_q        <= 1'b0;
      mac_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmp_pend_q  <= cmp_pend_d;
      cfg_valid_q <= cfg_valid_d;
      krows_q     <= krows_d;
      kcols_q     <= kcols_d;
      ctl_q       <= ctl_d;
      sel_q       <= sel_d;
      set_q       <= set_d;
      kw_q        <= kw_d;
      mac_q       <= mac_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign controlSignal = ctl_q;
  assign initPESelect  = sel_q;
  assign initSettings  = set_q;
  assign kernelWrite   = kw_q;
  assign macEn         = mac_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign cfgValid      = cfg_valid_q;

endmodule

// File: tb/tb_pe_loop_sequencer.sv
// Scoreboard bench: each op is expanded into its command list, expected cycles are queued as
// the driver steps the clock, and a negedge monitor pops and compares whenever busy or done is up.
module tb_pe_loop_sequencer;

  typedef struct packed {
    logic [5:0]  ctl;
    logic [15:0] sel;
    logic [1:0]  set;
    logic        kw;
    logic        mac;
    logic        busy;
    logic        done;
  } obs_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [6:0]  kRows = 7'd0;
  logic [6:0]  kCols = 7'd0;
  logic        stall = 1'b0;
  logic [5:0]  controlSignal;
  logic [15:0] initPESelect;
  logic [1:0]  initSettings;
  logic        kernelWrite, macEn, busy, done, cfgValid;

  pe_loop_sequencer dut (
    .CLK           (CLK),
    .RST           (RST),
    .start         (start),
    .mode          (mode),
    .kRows         (kRows),
    .kCols         (kCols),
    .stall         (stall),
    .controlSignal (controlSignal),
    .initPESelect  (initPESelect),
    .initSettings  (initSettings),
    .kernelWrite   (kernelWrite),
    .macEn         (macEn),
    .busy          (busy),
    .done          (done),
    .cfgValid      (cfgValid)
  );

  always #5 CLK = ~CLK;

  localparam obs_t IDLE_O = {6'b001001, 16'h0000, 2'b00, 4'b0000};
  localparam obs_t HOLD_O = {6'b001001, 16'h0000, 2'b00, 4'b0010};

  int   total = 0;
  int   bad = 0;
  obs_t exp_q[$];
  obs_t cmds[$];
  bit   cfg_ok = 1'b0;
  obs_t cur;
  obs_t mon_e;

  assign cur = {controlSignal, initPESelect, initSettings, kernelWrite, macEn, busy, done};

  function automatic obs_t mk(input int k, input int n, input int sel, input int set,
                              input bit kw, input bit mac, input bit bsy, input bit dn);
    obs_t o;
    o.ctl  = {3'(k), 3'(n)};
    o.sel  = 16'(sel);
    o.set  = 2'(set);
    o.kw   = kw;
    o.mac  = mac;
    o.busy = bsy;
    o.done = dn;
    return o;
  endfunction

  function automatic void add_cfg();
    for (int p = 0; p < 16; p++)
      for (int c = 0; c < 4; c++)
        cmds.push_back(mk(4 + c, 4 + c, 1 << p, (c % 2 == 1) ? p % 4 : p / 4, 0, 0, 1, 0));
  endfunction

  function automatic void build(input int md, input int kr, input int kc);
    cmds.delete();
    if (md == 0) add_cfg();
    if (md == 1) begin
      cmds.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0));
      for (int i = 0; i < kc; i++) cmds.push_back(mk(2, 1, 0, 0, 1, 0, 1, 0));
    end
    if (md == 2) begin
      if (!cfg_ok) add_cfg();
      cmds.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0));
      if (kr > 0 && kc > 0)
        for (int r = 0; r < kr; r++) begin
          for (int c = 0; c < kc; c++) cmds.push_back(mk(2, 2, 0, 0, 0, 1, 1, 0));
          cmds.push_back(mk(3, 3, 0, 0, 0, 0, 1, 0));
        end
    end
    cmds.push_back(mk(1, 1, 0, 0, 0, 0, 0, 1));
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (!RST && (busy || done)) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_output t=%0t got=%h", $time, cur);
      end else begin
        mon_e = exp_q.pop_front();
        if (cur !== mon_e) begin
          bad++;
          $display("FAIL seq_cycle t=%0t got ctl=%b sel=%h set=%0d kw=%b mac=%b busy=%b done=%b want ctl=%b sel=%h set=%0d kw=%b mac=%b busy=%b done=%b",
                   $time, cur.ctl, cur.sel, cur.set, cur.kw, cur.mac, cur.busy, cur.done,
                   mon_e.ctl, mon_e.sel, mon_e.set, mon_e.kw, mon_e.mac, mon_e.busy, mon_e.done);
        end
      end
    end
  end

  // Entered and left just after a rising edge.
  task automatic run_op(input int md, input int kr, input int kc, input int st_at,
                        input int st_len, input int poke, input int abort);
    int idx;
    int e;
    start = 1'b1;
    mode  = 2'(md);
    kRows = 7'(kr);
    kCols = 7'(kc);
    stall = 1'($urandom_range(0, 1));
    if (md == 3) begin
      @(posedge CLK); #1;
      start = 1'b0;
      stall = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      chk("reserved_ignored", {30'd0, busy, done}, 32'd0);
      return;
    end
    build(md, kr, kc);
    exp_q.push_back(cmds[0]);
    @(posedge CLK); #1;
    start = 1'b0;
    stall = 1'b0;
    kRows = 7'($urandom);
    kCols = 7'($urandom);
    idx = 1;
    e = 0;
    while (idx < cmds.size()) begin
      if (e == abort) begin
        RST = 1'b1;
        #1;
        chk("abort_outputs", 32'(cur), 32'(IDLE_O));
        chk("abort_cfgvalid", 32'(cfgValid), 32'd0);
        exp_q.delete();
        cfg_ok = 1'b0;
        stall = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b0;
        return;
      end
      stall = (st_len > 0) && (e >= st_at) && (e < st_at + st_len);
      start = (e == poke);
      if (e == poke) mode = 2'($urandom_range(0, 2));
      if (stall) exp_q.push_back(HOLD_O);
      else begin
        exp_q.push_back(cmds[idx]);
        idx++;
      end
      @(posedge CLK); #1;
      e++;
    end
    start = 1'b0;
    stall = 1'b0;
    if (md == 0 || md == 2) cfg_ok = 1'b1;
    chk("cfg_valid", 32'(cfgValid), 32'(cfg_ok));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_outputs", 32'(cur), 32'(IDLE_O));
    chk("reset_cfgvalid", 32'(cfgValid), 32'd0);
    RST = 1'b0;
    @(posedge CLK); #1;
    chk("idle_after_reset", 32'(cur), 32'(IDLE_O));

    run_op(0, 0, 0, 0, 0, -1, -1);    // full CONFIG walk
    run_op(1, 0, 5, 0, 0, -1, -1);    // LOAD 5 words
    run_op(2, 1, 4, 1, 2, -1, -1);    // stall over the 2nd INCR
    run_op(2, 0, 3, 0, 0, -1, -1);    // zero rows
    run_op(1, 0, 0, 0, 0, -1, -1);    // zero-length load
    run_op(2, 3, 0, 0, 0, -1, -1);    // zero cols
    run_op(2, 2, 3, 0, 0, 4, -1);     // start while busy
    run_op(3, 1, 1, 0, 0, -1, -1);    // reserved mode
    run_op(2, 3, 3, 0, 0, -1, 5);     // reset mid-compute
    run_op(2, 2, 3, 0, 0, -1, -1);    // CFG must rerun first

    for (int i = 0; i < 30; i++) begin
      int md, kr, kc, sa, sl, pk, ab, sel;
      sel = int'($urandom_range(0, 9));
      md  = (sel < 1) ? 3 : (sel < 3) ? 0 : (sel < 6) ? 1 : 2;
      kr  = int'($urandom_range(0, 4));
      kc  = int'($urandom_range(0, 6));
      sa  = int'($urandom_range(0, 10));
      sl  = int'($urandom_range(0, 3));
      pk  = -1;
      if ($urandom_range(0, 3) == 0) pk = int'($urandom_range(0, 8));
      ab  = -1;
      if ($urandom_range(0, 9) == 0) ab = int'($urandom_range(0, 12));
      run_op(md, kr, kc, sa, sl, pk, ab);
      repeat ($urandom_range(0, 2)) begin
        stall = 1'($urandom_range(0, 1));
        @(posedge CLK); #1;
      end
      stall = 1'b0;
    end

    repeat (3) @(posedge CLK);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
